// File: rtl/sdram_rd_prefetch.sv
// SDRAM burst-read prefetcher: walks a linear frame buffer in bursts and
// buffers the returned words in a same-clock FIFO for the display consumer.
module sdram_rd_prefetch #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 22,
  parameter int BURST_LEN   = 128,
  parameter int FIFO_DEPTH  = 512,
  parameter int BASE_ADDR   = 0,
  parameter int FRAME_WORDS = 307200,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_100m,
  input  logic              rst_n,
  input  logic              frame_start,
  output logic              rd_burst_req,
  output logic [9:0]        rd_burst_len,
  output logic [ADDR_W-1:0] rd_burst_addr,
  input  logic [DATA_W-1:0] rd_burst_data,
  input  logic              rd_burst_data_valid,
  input  logic              rd_burst_finish,
  input  logic              fifo_rd_en,
  output logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_empty,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow,
  output logic              underflow,
  output logic [2:0]        dbg_state_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int REM_W = $clog2(FRAME_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    REQ   = 3'd2,
    DATA  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic [9:0]          len_q, len_d;
  logic [ADDR_W-1:0]   baddr_q, baddr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

  logic                flush;
  logic                wr_req;
  logic                wr_acc;
  logic                rd_acc;
  logic                full;
  logic                empty;
  logic [9:0]          cur_len;
  logic [31:0]         space;

  // Burst sequencing, address walk and frame restart handling.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    len_d   = len_q;
    baddr_d = baddr_q;
    flush   = 1'b0;
    wr_req  = 1'b0;
    space   = 32'(FIFO_DEPTH) - 32'(level_q);
    if (32'(rem_q) < 32'(BURST_LEN)) cur_len = 10'(rem_q);
    else                             cur_len = 10'(BURST_LEN);

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          flush   = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (frame_start) begin
          flush = 1'b1;
        end else if (space >= 32'(cur_len)) begin
          state_d = REQ;
          len_d   = cur_len;
          baddr_d = addr_q;
        end
      end
      REQ, DATA: begin
        // A word arriving together with frame_start belongs to the old frame.
        wr_req = rd_burst_data_valid && !frame_start;
        if (rd_burst_finish) begin
          state_d = CHECK;
          if (frame_start) begin
            flush = 1'b1;
          end else if (rem_q == REM_W'(len_q)) begin
            addr_d = ADDR_W'(BASE_ADDR);
            rem_d  = REM_W'(FRAME_WORDS);
          end else begin
            addr_d = addr_q + ADDR_W'(len_q);
            rem_d  = rem_q - REM_W'(len_q);
          end
        end else if (frame_start) begin
          state_d = DRAIN;
        end else if (state_q == REQ && rd_burst_data_valid) begin
          state_d = DATA;
        end
      end
      DRAIN: begin
        if (rd_burst_finish) begin
          flush   = 1'b1;
          state_d = CHECK;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      addr_d = ADDR_W'(BASE_ADDR);
      rem_d  = REM_W'(FRAME_WORDS);
    end
  end

  // FIFO bookkeeping; flush overrides any push or pop in the same cycle.
  always_comb begin
    full     = (level_q == LVL_W'(FIFO_DEPTH));
    empty    = (level_q == '0);
    rd_acc   = fifo_rd_en && !empty && !flush;
    wr_acc   = wr_req && (!full || rd_acc) && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    dout_d   = dout_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        dout_d   = mem_q[rd_ptr_q];
      end
      if (wr_acc && !rd_acc)      level_d = level_q + LVL_W'(1);
      else if (rd_acc && !wr_acc) level_d = level_q - LVL_W'(1);
      if (wr_req && !wr_acc)      ovf_d = 1'b1;
      if (fifo_rd_en && empty)    udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= ADDR_W'(BASE_ADDR);
      rem_q    <= REM_W'(FRAME_WORDS);
      len_q    <= '0;
      baddr_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      len_q    <= len_d;
      baddr_q  <= baddr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array carries no reset; the pointers and level define its contents.
  always_ff @(posedge clk_100m) begin
    if (wr_acc) mem_q[wr_ptr_q] <= rd_burst_data;
  end

  assign rd_burst_req  = (state_q == REQ);
  assign rd_burst_len  = len_q;
  assign rd_burst_addr = baddr_q;
  assign fifo_dout     = dout_q;
  assign fifo_empty    = empty;
  assign fifo_level    = level_q;
  assign overflow      = ovf_q;
  assign underflow     = udf_q;
  assign dbg_state_o   = state_q;

endmodule
